// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin controller that serializes NREQ requesters
// onto one external combinational ALU.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester issue handshake (ready is one-hot or zero)
//   req_a/req_b/req_op          packed per-requester operands and opcode
//   alu_a/alu_b/alu_op          registered operands presented to the ALU
//   alu_result                  combinational ALU result
//   resp_valid/resp_ready       response handshake
//   resp_result/resp_id/resp_err registered result, owner index, illegal-op flag
module alu_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_result,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_err
);

    // candidate index needs one spare bit so ptr+k never overflows before the modulo
    localparam int unsigned CW = IDW + 1;
    localparam logic [2:0]  OP_MAX_LEGAL = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             accept;
    logic [CW-1:0]    cand;

    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [2:0]       op_arr [NREQ];

    // unpack per-requester payloads
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
        assign op_arr[i] = req_op[i*3 +: 3];
    end

    // round-robin search starting just after the last granted index
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and combinational accept
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_found) begin
                    req_ready = NREQ'(1) << gnt_idx;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, result capture; ptr doubles as the latched owner index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= IDW'(NREQ - 1);
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_id     <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                ptr    <= gnt_idx;
                alu_a  <= a_arr[gnt_idx];
                alu_b  <= b_arr[gnt_idx];
                alu_op <= op_arr[gnt_idx];
            end
            if (state == EXEC) begin
                resp_result <= (alu_op > OP_MAX_LEGAL) ? '0 : alu_result;
                resp_id     <= ptr;
                resp_err    <= (alu_op > OP_MAX_LEGAL);
            end
            resp_valid <= (state_nxt == RESP);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ*3-1:0]     req_op = '0;
    logic [WIDTH-1:0]      alu_a, alu_b, alu_result;
    logic [2:0]            alu_op;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [WIDTH-1:0]      resp_result;
    logic [IDW-1:0]        resp_id;
    logic                  resp_err;

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_id(resp_id), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // external ALU; illegal opcodes return garbage the arbiter must suppress
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 16'hDEAD;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] op);
        int unsigned s;
        case (op)
            3'd0: s = (int'(a) + int'(b)) % 65536;
            3'd1: s = (int'(a) - int'(b) + 65536) % 65536;
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = int'(a ^ b);
            default: s = 0;
        endcase
        return 16'(s);
    endfunction

    // ---- transaction-level reference model: at most one outstanding txn ----
    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
        int          t;
    } txn_t;

    txn_t            pend[$];
    int              cyc = 0;
    int              m_last = NREQ - 1;
    logic [15:0]     m_a = '0, m_b = '0, s_res = '0;
    logic [2:0]      m_op = '0;
    int              s_id = 0;
    logic            s_err = 1'b0;
    logic [NREQ-1:0] acc_mask = '0;

    always @(negedge clk) begin
        int          win;
        logic [NREQ-1:0] exp_rdy;
        logic        due;
        logic [2:0]  op_w;
        txn_t        tx;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            m_last = NREQ - 1;
            m_a = '0; m_b = '0; m_op = '0;
            s_res = '0; s_id = 0; s_err = 1'b0;
            acc_mask = '0;
        end else begin
            win = -1;
            if (pend.size() == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (win < 0 && req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            due = (pend.size() > 0) && (cyc >= pend[0].t + 2);
            if (due) begin
                s_res = pend[0].res; s_id = pend[0].id; s_err = pend[0].err;
            end
            check("m_req_ready",   32'(req_ready),   32'(exp_rdy));
            check("m_resp_valid",  32'(resp_valid),  32'(due));
            check("m_alu_a",       32'(alu_a),       32'(m_a));
            check("m_alu_b",       32'(alu_b),       32'(m_b));
            check("m_alu_op",      32'(alu_op),      32'(m_op));
            check("m_resp_result", 32'(resp_result), 32'(s_res));
            check("m_resp_id",     32'(resp_id),     32'(s_id));
            check("m_resp_err",    32'(resp_err),    32'(s_err));
            if (due && resp_ready) void'(pend.pop_front());
            if (win >= 0) begin
                m_a  = req_a[win*WIDTH +: WIDTH];
                m_b  = req_b[win*WIDTH +: WIDTH];
                op_w = req_op[win*3 +: 3];
                m_op = op_w;
                m_last = win;
                tx.id  = win;
                tx.err = (op_w > 3'd4);
                tx.res = ref_result(m_a, m_b, op_w);
                tx.t   = cyc;
                pend.push_back(tx);
            end
            acc_mask = exp_rdy;
        end
    end

    // ---- stimulus helpers ----
    bit auto_drop = 1'b1;
    int tcount = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
        tcount++;
        if (auto_drop) req_valid = req_valid & ~acc_mask;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i*3 +: 3]        = op;
        req_valid[i]            = 1'b1;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("rst_all_zero", {req_ready, resp_valid, resp_result, 32'(resp_id), resp_err},
              32'd0);
        check("rst_alu_zero", {alu_a, alu_b}, 32'd0);
        check("rst_alu_op",   32'(alu_op), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    logic [15:0] rr_exp [4];
    int          t_prev;
    logic [15:0] held_res;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp[0] = 16'h00F0; rr_exp[1] = 16'hFFF0;
        rr_exp[2] = 16'hFF00; rr_exp[3] = 16'h00E0;
        #2;
        do_reset();

        // single request from requester 2
        set_req(2, 16'h1234, 16'h0FF0, 3'd0);
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        cycle();
        check("single_ready_low", 32'(req_ready), 32'd0);
        check("single_alu_a", 32'(alu_a), 32'h1234);
        check("single_exec_no_valid", 32'(resp_valid), 32'd0);
        cycle();
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_result", 32'(resp_result), 32'h2224);
        check("single_id", 32'(resp_id), 32'd2);
        check("single_err", 32'(resp_err), 32'd0);
        cycle();

        // wrap-around
        set_req(0, 16'h0000, 16'h0001, 3'd1);
        wait_resp("wrap_sub");
        check("wrap_sub_result", 32'(resp_result), 32'hFFFF);
        cycle();
        set_req(0, 16'hFFFF, 16'h0001, 3'd0);
        wait_resp("wrap_add");
        check("wrap_add_result", 32'(resp_result), 32'h0000);
        cycle();

        // illegal opcode
        set_req(3, 16'h5555, 16'hAAAA, 3'b110);
        wait_resp("illegal");
        check("illegal_err", 32'(resp_err), 32'd1);
        check("illegal_result", 32'(resp_result), 32'h0000);
        check("illegal_id", 32'(resp_id), 32'd3);
        cycle();

        // round-robin with every requester continuously valid
        do_reset();
        auto_drop = 1'b0;
        set_req(0, 16'hF0F0, 16'h0FF0, 3'd2);
        set_req(1, 16'hF0F0, 16'h0FF0, 3'd3);
        set_req(2, 16'hF0F0, 16'h0FF0, 3'd4);
        set_req(3, 16'hF0F0, 16'h0FF0, 3'd0);
        #1;
        check("rr_first_ready", 32'(req_ready), 32'b0001);
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_resp("rr");
            check("rr_id", 32'(resp_id), 32'(g % 4));
            check("rr_result", 32'(resp_result), 32'(rr_exp[g % 4]));
            if (g > 0) check("rr_interval", 32'(tcount - t_prev), 32'd3);
            t_prev = tcount;
            cycle();
        end
        req_valid = '0;
        auto_drop = 1'b1;
        repeat (3) cycle();

        // backpressure with requester 1 waiting
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 16'h0003, 16'h0004, 3'd0);
        set_req(1, 16'h00FF, 16'h0F0F, 3'd2);
        wait_resp("bp");
        held_res = resp_result;
        check("bp_result", 32'(held_res), 32'h0007);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_valid_held", 32'(resp_valid), 32'd1);
            check("bp_result_held", 32'(resp_result), 32'(held_res));
            check("bp_ready_zero", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        cycle();
        check("bp_next_grant", 32'(req_ready), 32'b0010);
        wait_resp("bp_second");
        check("bp_second_id", 32'(resp_id), 32'd1);
        check("bp_second_result", 32'(resp_result), 32'h000F);
        cycle();

        // reset while in EXEC
        set_req(1, 16'h1111, 16'h2222, 3'd0);
        cycle();
        check("rexec_alu_a", 32'(alu_a), 32'h1111);
        rst_n = 1'b0;
        #1;
        check("rexec_outs", {req_ready, resp_valid, resp_result, 32'(resp_id), resp_err}, 32'd0);
        check("rexec_alu", {alu_a, alu_b}, 32'd0);
        check("rexec_alu_op", 32'(alu_op), 32'd0);
        req_valid = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rexec_no_resp", 32'(resp_valid), 32'd0);
        end
        set_req(2, 16'h0001, 16'h0001, 3'd0);
        set_req(0, 16'h0002, 16'h0002, 3'd0);
        #1;
        check("rexec_prio0", 32'(req_ready), 32'b0001);
        wait_resp("rexec");
        check("rexec_id", 32'(resp_id), 32'd0);
        repeat (8) cycle();

        // randomized traffic under random backpressure
        for (int n = 0; n < 1500; n++) begin
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    logic [15:0] a, b;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
                    if ($urandom_range(0, 7) == 0) b = 16'h0000;
                    set_req(i, a, b, 3'($urandom_range(0, 7)));
                end
            end
            cycle();
        end
        resp_ready = 1'b1;
        repeat (40) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
